// File: rtl/serial_to_parallel_rx.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words MSB- or LSB-first
// and offers each completed word through a one-deep valid/ready output buffer.
module serial_to_parallel_rx #(
  parameter int WIDTH = 4,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             SERIN,
  input  logic             SERVALID,
  input  logic             MSB_FIRST,
  input  logic             CLEAR,
  input  logic             DOUT_READY,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             DOUT_VALID,
  output logic             BUSY,
  output logic [CNTW-1:0]  BITCNT,
  output logic             OVERRUN
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state, state_n;
  logic [CNTW-1:0]    bitcnt_q, bitcnt_n;
  logic [WIDTH-1:0]   sreg_q, sreg_n;
  logic               order_q, order_n;
  logic [WIDTH-1:0]   data_q, data_n;
  logic               valid_q, valid_n;
  logic               overrun_q, overrun_n;

  logic               order_eff;
  logic [WIDTH-1:0]   shifted;
  logic               last_bit;
  logic               consume;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bitcnt_q  <= '0;
      sreg_q    <= '0;
      order_q   <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt_q  <= bitcnt_n;
      sreg_q    <= sreg_n;
      order_q   <= order_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      overrun_q <= overrun_n;
    end
  end

  // The first bit of a frame uses the live MSB_FIRST; later bits use the latched order.
  always_comb begin
    order_eff = (state == IDLE) ? MSB_FIRST : order_q;
    shifted   = order_eff ? {sreg_q[WIDTH-2:0], SERIN} : {SERIN, sreg_q[WIDTH-1:1]};
    last_bit  = (bitcnt_q == CNTW'(WIDTH - 1));
    consume   = valid_q && DOUT_READY;
  end

  always_comb begin
    state_n   = state;
    bitcnt_n  = bitcnt_q;
    sreg_n    = sreg_q;
    order_n   = order_q;
    data_n    = data_q;
    valid_n   = valid_q;
    overrun_n = overrun_q;

    if (consume) begin
      valid_n = 1'b0;
    end

    if (CLEAR) begin
      state_n   = IDLE;
      bitcnt_n  = '0;
      sreg_n    = '0;
      overrun_n = 1'b0;
    end else if (SERVALID) begin
      if (state == IDLE) begin
        order_n = MSB_FIRST;
      end
      if (last_bit) begin
        state_n  = IDLE;
        bitcnt_n = '0;
        sreg_n   = '0;
        // A full, unconsumed buffer drops the new word and flags it.
        if (!valid_q || DOUT_READY) begin
          data_n  = shifted;
          valid_n = 1'b1;
        end else begin
          overrun_n = 1'b1;
        end
      end else begin
        state_n  = SHIFT;
        bitcnt_n = bitcnt_q + CNTW'(1);
        sreg_n   = shifted;
      end
    end
  end

  assign DATAOUT    = data_q;
  assign DOUT_VALID = valid_q;
  assign BUSY       = (state == SHIFT);
  assign BITCNT     = bitcnt_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: a frame-level reference model
// checked every cycle, plus directed scenarios with hand-computed words.
module tb_serial_to_parallel_rx;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          serin = 1'b0;
  logic          servalid = 1'b0;
  logic          msb_first = 1'b1;
  logic          clear = 1'b0;
  logic          dout_ready = 1'b0;
  logic [W-1:0]  dataout;
  logic          dout_valid;
  logic          busy;
  logic [CW-1:0] bitcnt;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  serial_to_parallel_rx #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .SERIN      (serin),
    .SERVALID   (servalid),
    .MSB_FIRST  (msb_first),
    .CLEAR      (clear),
    .DOUT_READY (dout_ready),
    .DATAOUT    (dataout),
    .DOUT_VALID (dout_valid),
    .BUSY       (busy),
    .BITCNT     (bitcnt),
    .OVERRUN    (overrun)
  );

  always #5 clock = ~clock;

  // Reference model: collects the frame's bits, then places bit i at its final position.
  logic         m_bits [W];
  int           m_cnt;
  logic         m_order;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_over;

  always @(posedge clock) begin : model
    logic [W-1:0] word;
    logic         done;
    logic         consumed;
    if (reset) begin
      m_cnt   = 0;
      m_order = 1'b1;
      m_data  = '0;
      m_valid = 1'b0;
      m_over  = 1'b0;
    end else begin
      consumed = m_valid && dout_ready;
      done     = 1'b0;
      word     = '0;
      if (clear) begin
        m_cnt  = 0;
        m_over = 1'b0;
      end else if (servalid) begin
        if (m_cnt == 0) m_order = msb_first;
        m_bits[m_cnt] = serin;
        m_cnt++;
        if (m_cnt == W) begin
          done  = 1'b1;
          m_cnt = 0;
          for (int i = 0; i < W; i++) begin
            word[m_order ? (W - 1 - i) : i] = m_bits[i];
          end
        end
      end
      if (done && (!m_valid || dout_ready)) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        if (done) m_over = 1'b1;
        if (consumed) m_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("model DATAOUT", 32'(dataout), 32'(m_data));
    checkOutput("model DOUT_VALID", 32'(dout_valid), 32'(m_valid));
    checkOutput("model BUSY", 32'(busy), 32'(m_cnt != 0));
    checkOutput("model BITCNT", 32'(bitcnt), 32'(m_cnt));
    checkOutput("model OVERRUN", 32'(overrun), 32'(m_over));
  endtask

  // One clock per call: drive, let the edge happen, then compare on the falling edge.
  task automatic applyStimulus(input logic s, input logic v, input logic m,
                               input logic c, input logic r);
    serin      = s;
    servalid   = v;
    msb_first  = m;
    clear      = c;
    dout_ready = r;
    @(posedge clock);
    @(negedge clock);
    compareModel();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, r);
  endtask

  task automatic sendWord(input logic [W-1:0] w, input logic msb, input logic r);
    for (int i = 0; i < W; i++) begin
      applyStimulus(msb ? w[W-1-i] : w[i], 1'b1, msb, 1'b0, r);
    end
  endtask

  initial begin
    $display("[TB] start");
    idle(2, 1'b0);
    checkOutput("reset DATAOUT", 32'(dataout), 32'h0);
    checkOutput("reset DOUT_VALID", 32'(dout_valid), 32'h0);
    checkOutput("reset BITCNT", 32'(bitcnt), 32'h0);
    reset = 1'b0;

    // MSB-first 1,0,1,1 back to back
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t1 bitcnt after bit1", 32'(bitcnt), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t1 bitcnt after bit2", 32'(bitcnt), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t1 bitcnt after bit3", 32'(bitcnt), 32'd3);
    checkOutput("t1 busy mid-frame", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t1 bitcnt after bit4", 32'(bitcnt), 32'd0);
    checkOutput("t1 dataout", 32'(dataout), 32'hB);
    checkOutput("t1 dout_valid", 32'(dout_valid), 32'd1);
    idle(1, 1'b1);
    checkOutput("t1 consumed", 32'(dout_valid), 32'd0);
    checkOutput("t1 dataout held", 32'(dataout), 32'hB);

    // LSB-first 1,0,1,1 with gaps; MSB_FIRST raised after the first bit
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2 dataout", 32'(dataout), 32'hD);
    checkOutput("t2 dout_valid", 32'(dout_valid), 32'd1);
    idle(1, 1'b1);

    // Overrun while the buffer is held, then CLEAR
    sendWord(4'b1011, 1'b1, 1'b0);
    sendWord(4'b0110, 1'b1, 1'b0);
    checkOutput("t3 dataout kept", 32'(dataout), 32'hB);
    checkOutput("t3 overrun", 32'(overrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t3 overrun cleared", 32'(overrun), 32'd0);
    checkOutput("t3 valid survives clear", 32'(dout_valid), 32'd1);
    idle(1, 1'b1);

    // Back-to-back frames, then completion coinciding with consumption
    sendWord(4'b0001, 1'b1, 1'b1);
    checkOutput("t4 first word", 32'(dataout), 32'h1);
    sendWord(4'b1000, 1'b1, 1'b1);
    checkOutput("t4 second word", 32'(dataout), 32'h8);
    checkOutput("t4 no overrun", 32'(overrun), 32'd0);
    idle(1, 1'b1);
    sendWord(4'b0011, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t4 swap dataout", 32'(dataout), 32'hC);
    checkOutput("t4 swap valid", 32'(dout_valid), 32'd1);
    checkOutput("t4 swap no overrun", 32'(overrun), 32'd0);
    idle(1, 1'b1);

    // Abort a partial frame with CLEAR while SERVALID is high
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t5 bitcnt before clear", 32'(bitcnt), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t5 bitcnt after clear", 32'(bitcnt), 32'd0);
    checkOutput("t5 busy after clear", 32'(busy), 32'd0);
    sendWord(4'b1110, 1'b1, 1'b1);
    checkOutput("t5 dataout", 32'(dataout), 32'hE);
    idle(1, 1'b1);

    // CLEAR on the completing edge produces no word
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t5b no word", 32'(dout_valid), 32'd0);
    checkOutput("t5b dataout held", 32'(dataout), 32'hE);

    // Reset mid-frame with a word pending
    sendWord(4'b1001, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6 bitcnt before reset", 32'(bitcnt), 32'd3);
    reset = 1'b1;
    idle(1, 1'b0);
    reset = 1'b0;
    checkOutput("t6 dataout", 32'(dataout), 32'h0);
    checkOutput("t6 dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("t6 bitcnt", 32'(bitcnt), 32'd0);
    checkOutput("t6 busy", 32'(busy), 32'd0);
    sendWord(4'b0101, 1'b1, 1'b1);
    checkOutput("t6 clean frame", 32'(dataout), 32'h5);
    checkOutput("t6 clean valid", 32'(dout_valid), 32'd1);
    idle(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
